// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice: FSM state encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int unsigned W = $clog2(CLKS_PER_BIT);

  logic [W-1:0] count;

  assign tc = (count == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] writedata,
  input  logic       enable,
  output logic       active,
  output logic       done,
  output logic       tx
);

  state_t               state;
  logic [DATA_BITS-1:0] data_q;
  logic [2:0]           idx;
  logic                 tc;

  // Held clear while idle so the first bit period starts counting on the edge after accept.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .clear(state == IDLE),
    .tc   (tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      data_q <= '0;
      idx    <= '0;
      tx     <= 1'b1;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable) begin
            data_q <= writedata;
            active <= 1'b1;
            idx    <= '0;
            state  <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (tc) begin
            idx   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          tx <= data_q[idx];
          if (tc) begin
            if (idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (tc) begin
            done   <= 1'b1;
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx against a frame-level reference model.
module tb_uart_tx;

  localparam int unsigned C = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] writedata;
  logic       active;
  logic       done;
  logic       tx;

  int checks   = 0;
  int failures = 0;

  uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .writedata(writedata),
    .enable   (enable),
    .active   (active),
    .done     (done),
    .tx       (tx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_active", 32'(active), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end
  endtask

  // Called at a sample point (#1 after an edge); returns at the sample point right after done.
  // Expected line level at cycle t after accept is frame bit (t-1)/C, frame = {stop, data, start}.
  task automatic send(input logic [7:0] b, input bit noise);
    logic [9:0] frame;
    frame     = {1'b1, b, 1'b0};
    writedata = b;
    enable    = 1'b1;
    @(posedge clock);
    #1;
    check("accept_tx", 32'(tx), 32'd1);
    check("accept_active", 32'(active), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    enable = 1'b0;
    for (int t = 1; t <= int'(10 * C); t++) begin
      writedata = 8'($urandom);
      if (noise) enable = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      check($sformatf("tx_%02h_t%0d", b, t), 32'(tx), 32'(frame[(t - 1) / int'(C)]));
      check($sformatf("active_%02h_t%0d", b, t), 32'(active), 32'(t < int'(10 * C)));
      check($sformatf("done_%02h_t%0d", b, t), 32'(done), 32'(t == int'(10 * C)));
    end
    enable = 1'b0;
  endtask

  initial begin
    logic [7:0] burst [4];
    int         wait_cycles;
    burst = '{8'hAB, 8'hAC, 8'hAD, 8'hAF};

    reset     = 1'b0;
    enable    = 1'b0;
    writedata = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_active", 32'(active), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b1;
    idle(2);

    send(8'hAA, 1'b0);
    idle(1);

    foreach (burst[i]) send(burst[i], 1'b0);
    idle(1);

    send(8'h0F, 1'b1);
    idle(1);

    repeat (6) begin
      send(8'($urandom), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)));
    end

    writedata = 8'hFF;
    enable    = 1'b1;
    @(posedge clock);
    #1;
    enable      = 1'b0;
    wait_cycles = int'($urandom_range(C + 1, 9 * C));
    repeat (wait_cycles) @(posedge clock);
    #1;
    check("pre_reset_tx", 32'(tx), 32'd1);
    check("pre_reset_active", 32'(active), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_active", 32'(active), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check("held_reset_active", 32'(active), 32'd0);
    reset = 1'b1;
    idle(1);
    send(8'h3C, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
